// File: rtl/bru_pkg.sv
// Shared types and default sizing for the branch resolve unit.
// Optional performance counters in the top are enabled by BRU_PERF_CNT_EN.
package bru_pkg;

    localparam int BRU_DEPTH = 4;
    localparam int BRU_XLEN  = 32;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic [BRU_XLEN-1:0] pc;
        logic                pred_taken;
        logic [BRU_XLEN-1:0] pred_target;
    } bru_entry_t;

endpackage

// File: rtl/bru_pred_queue.sv
// Ordered FIFO of in-flight branch predictions; pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module bru_pred_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [W-1:0]             head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr == {~rd_ptr[PW-1], rd_ptr[AW-1:0]});
    assign count     = wr_ptr - rd_ptr;
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Pop frees a slot first, so a push into a full queue is legal when paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: checks the oldest prediction, redirects on a miss
// and trains the predictor. Define BRU_PERF_CNT_EN to build br_count/mp_count.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH = BRU_DEPTH,
    parameter int XLEN  = BRU_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [XLEN-1:0]          push_pc,
    input  logic                     push_pred_taken,
    input  logic [XLEN-1:0]          push_pred_target,
    output logic                     push_ready,
    input  logic                     res_valid,
    input  logic [XLEN-1:0]          res_pc,
    input  logic                     res_taken,
    input  logic [XLEN-1:0]          res_target,
    output logic                     upd_valid,
    output logic [XLEN-1:0]          upd_pc,
    output logic                     upd_taken,
    output logic [XLEN-1:0]          upd_target,
    output logic                     misprediction,
    output logic                     redirect_valid,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     flush,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     order_err,
    output logic [31:0]              br_count,
    output logic [31:0]              mp_count
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * XLEN + 1;

    bru_state_e     state_q;
    bru_state_e     state_d;

    logic           q_full;
    logic           q_empty;
    logic [PW-1:0]  q_count;
    logic [EW-1:0]  head_word;
    logic [XLEN-1:0] head_pc;
    logic           head_taken;
    logic [XLEN-1:0] head_target;

    logic           res_fire;
    logic           head_match;
    logic           good_res;
    logic           bad_res;
    logic           mispred;
    logic           q_push;
    logic           q_pop;
    logic [XLEN-1:0] next_pc;

    assign {head_pc, head_taken, head_target} = head_word;

    assign res_fire   = res_valid && (state_q == RUN);
    assign head_match = !q_empty && (res_pc == head_pc);
    assign good_res   = res_fire && head_match;
    assign bad_res    = res_fire && !head_match;
    assign mispred    = good_res &&
                        ((head_taken != res_taken) ||
                         (head_taken && res_taken && (head_target != res_target)));

    // A full queue still accepts a push when a resolve frees the head this cycle.
    assign push_ready = (state_q == RUN) && (!q_full || res_valid);
    assign q_pop      = res_fire && !q_empty;
    assign q_push     = push_valid && push_ready && !mispred;
    assign next_pc    = res_taken ? res_target : head_pc + XLEN'(4);
    assign occupancy  = q_count;

    bru_pred_queue #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({push_pc, push_pred_taken, push_pred_target}),
        .pop       (q_pop),
        .clear     (mispred),
        .head_data (head_word),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mispred) state_d = REDIRECT;
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            upd_target     <= '0;
            misprediction  <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            order_err      <= 1'b0;
        end else begin
            upd_valid      <= good_res;
            misprediction  <= mispred;
            redirect_valid <= mispred;
            flush          <= mispred;
            if (good_res) begin
                upd_pc     <= head_pc;
                upd_taken  <= res_taken;
                upd_target <= res_target;
            end
            if (mispred) redirect_pc <= next_pc;
            if (bad_res) order_err   <= 1'b1;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (good_res && (br_count != 32'hFFFF_FFFF)) br_count <= br_count + 32'd1;
            if (mispred && (mp_count != 32'hFFFF_FFFF))  mp_count <= mp_count + 32'd1;
        end
    end
`else
    assign br_count = '0;
    assign mp_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference queue model predicts each
// cycle's pulses, update fields and occupancy.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clk;
    logic              rst;
    logic              push_valid;
    logic [XLEN-1:0]   push_pc;
    logic              push_pred_taken;
    logic [XLEN-1:0]   push_pred_target;
    logic              push_ready;
    logic              res_valid;
    logic [XLEN-1:0]   res_pc;
    logic              res_taken;
    logic [XLEN-1:0]   res_target;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              misprediction;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              flush;
    logic [2:0]        occupancy;
    logic              order_err;
    logic [31:0]       br_count;
    logic [31:0]       mp_count;

    branch_resolve_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_ready       (push_ready),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .misprediction    (misprediction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .occupancy        (occupancy),
        .order_err        (order_err),
        .br_count         (br_count),
        .mp_count         (mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        upd_v;
        logic [31:0] upd_pc;
        logic        upd_t;
        logic [31:0] upd_tg;
        logic        mp;
        logic [31:0] rpc;
        logic        oerr;
        int          occ;
    } exp_t;

    exp_t       sb[$];
    bru_entry_t mq[$];
    logic       m_redir = 1'b0;
    logic       m_oerr  = 1'b0;

    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                        input logic [31:0] ptg, input logic rv, input logic [31:0] rpc_i,
                        input logic rt, input logic [31:0] rtg);
        exp_t       e;
        exp_t       got_e;
        logic       ready;
        logic       mp;
        bru_entry_t h;
        bru_entry_t n;
        push_valid       = pv;
        push_pc          = ppc;
        push_pred_taken  = pt;
        push_pred_target = ptg;
        res_valid        = rv;
        res_pc           = rpc_i;
        res_taken        = rt;
        res_target       = rtg;
        #1;
        ready = !m_redir && ((mq.size() < DEPTH) || rv);
        chk("push_ready", 64'(push_ready), 64'(ready));
        e.upd_v = 1'b0; e.upd_pc = '0; e.upd_t = 1'b0; e.upd_tg = '0;
        e.rpc = '0;
        mp = 1'b0;
        if (rv && !m_redir) begin
            if (mq.size() == 0 || mq[0].pc != rpc_i) begin
                m_oerr = 1'b1;
                if (mq.size() != 0) void'(mq.pop_front());
            end else begin
                h = mq.pop_front();
                e.upd_v  = 1'b1;
                e.upd_pc = h.pc;
                e.upd_t  = rt;
                e.upd_tg = rtg;
                mp = (h.pred_taken != rt) || (rt && (h.pred_target != rtg));
                if (mp) e.rpc = rt ? rtg : h.pc + 32'd4;
            end
        end
        if (pv && ready && !mp) begin
            n.pc = ppc; n.pred_taken = pt; n.pred_target = ptg;
            mq.push_back(n);
        end
        if (mp) mq.delete();
        m_redir = mp;
        e.mp   = mp;
        e.oerr = m_oerr;
        e.occ  = mq.size();
        sb.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        chk("upd_valid", 64'(upd_valid), 64'(got_e.upd_v));
        if (got_e.upd_v) begin
            chk("upd_pc", 64'(upd_pc), 64'(got_e.upd_pc));
            chk("upd_taken", 64'(upd_taken), 64'(got_e.upd_t));
            chk("upd_target", 64'(upd_target), 64'(got_e.upd_tg));
        end
        chk("misprediction", 64'(misprediction), 64'(got_e.mp));
        chk("redirect_valid", 64'(redirect_valid), 64'(got_e.mp));
        chk("flush", 64'(flush), 64'(got_e.mp));
        if (got_e.mp) chk("redirect_pc", 64'(redirect_pc), 64'(got_e.rpc));
        chk("order_err", 64'(order_err), 64'(got_e.oerr));
        chk("occupancy", 64'(occupancy), 64'(got_e.occ));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
        step(1'b1, pc, pt, tg, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b0, '0, 1'b0, '0, 1'b1, pc, t, tg);
    endtask

    task automatic drive_idle();
        push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_upd_pc", 64'(upd_pc), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_order_err", 64'(order_err), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_br_count", 64'(br_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_push_ready", 64'(push_ready), 64'd1);

        // correct not-taken prediction
        push(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b0, 32'h0);

        // taken with wrong target; push and resolve during REDIRECT are ignored
        push(32'h200, 1'b1, 32'h300);
        resolve(32'h200, 1'b1, 32'h340);
        step(1'b1, 32'h260, 1'b0, '0, 1'b1, 32'h999, 1'b0, '0);
        idle();

        // wrong direction kills younger entries
        push(32'h400, 1'b1, 32'h500);
        push(32'h404, 1'b1, 32'h500);
        push(32'h408, 1'b1, 32'h500);
        resolve(32'h400, 1'b0, 32'h0);
        idle();

        // fill, drop a 5th push, then push+resolve while full and wrap pointers
        for (int i = 0; i < DEPTH; i++) push(32'h600 + 32'(4 * i), 1'(i & 1), 32'h700 + 32'(i));
        push(32'h6F0, 1'b0, 32'h0);
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 32'h800 + 32'(4 * i), 1'(i & 1), 32'h900 + 32'(i),
                 1'b1, mq[0].pc, mq[0].pred_taken, mq[0].pred_target);
        end
        while (mq.size() != 0) resolve(mq[0].pc, mq[0].pred_taken, mq[0].pred_target);

        // ordering errors: empty queue, then PC mismatch against the head
        resolve(32'h500, 1'b0, 32'h0);
        idle();
        push(32'h504, 1'b0, 32'h0);
        resolve(32'h500, 1'b0, 32'h0);
        idle();

        // asynchronous reset in the middle of a redirect
        push(32'h700, 1'b1, 32'h800);
        push(32'h704, 1'b0, 32'h0);
        resolve(32'h700, 1'b0, 32'h0);
        drive_idle();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_flush", 64'(flush), 64'd0);
        chk("midrst_misprediction", 64'(misprediction), 64'd0);
        chk("midrst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("midrst_order_err", 64'(order_err), 64'd0);
        chk("midrst_occupancy", 64'(occupancy), 64'd0);
        mq.delete();
        m_redir = 1'b0;
        m_oerr  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle();

        // counters: three good resolves, one of them a mispredict
        push(32'h900, 1'b0, 32'h0);
        resolve(32'h900, 1'b0, 32'h0);
        push(32'h904, 1'b1, 32'hA00);
        resolve(32'h904, 1'b1, 32'hA00);
        push(32'h908, 1'b1, 32'hB00);
        resolve(32'h908, 1'b0, 32'h0);
        idle();
`ifdef BRU_PERF_CNT_EN
        chk("br_count", 64'(br_count), 64'd3);
        chk("mp_count", 64'(mp_count), 64'd1);
`else
        chk("br_count", 64'(br_count), 64'd0);
        chk("mp_count", 64'(mp_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage counterpart of the fetch-side branch predictor. Holds the prediction made for each in-flight branch in an ordered queue. Compares the head entry against the actual outcome resolved in EX, and raises redirect and flush on a misprediction. Drives the predictor's update port (resolved PC, direction and target) so the predictor can train its counters.

## Interface
- `DEPTH`, 4: in-flight prediction entries; must be a power of 2, at least 2.
- `XLEN`, 32: PC width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `push_valid` in 1: fetch issues a predicted branch.
- `push_pc` in XLEN: PC of that branch.
- `push_pred_taken` in 1: predicted direction.
- `push_pred_target` in XLEN: predicted target.
- `push_ready` out 1: queue can accept; a push is taken only when `push_valid & push_ready`.
- `res_valid` in 1: EX resolved the oldest branch.
- `res_pc` in XLEN: PC of the resolved branch.
- `res_taken` in 1: actual direction.
- `res_target` in XLEN: actual taken target.
- `upd_valid` out 1: one-cycle predictor update strobe.
- `upd_pc` out XLEN: PC being trained.
- `upd_taken` out 1: outcome used for training.
- `upd_target` out XLEN: target used for training.
- `misprediction` out 1: one-cycle pulse.
- `redirect_valid` out 1: fetch redirect pulse.
- `redirect_pc` out XLEN: correct next PC.
- `flush` out 1: kill wrong-path IF/ID.
- `occupancy` out $clog2(DEPTH)+1: current number of queued entries.
- `order_err` out 1: sticky error flag.
- `br_count` out 32: resolved-branch counter.
- `mp_count` out 32: misprediction counter.

## Operation
- Queue is a FIFO.
  - Read/write pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - Full when the pointers differ only in the MSB; empty when they are equal.
- Push is accepted when the queue is not full and the FSM is in RUN.
- Resolve when the queue is non-empty: pop the head and compare.
  - Mispredict when `pred_taken != res_taken`, or when both are taken and `pred_target != res_target`.
  - `redirect_pc = res_taken ? res_target : head_pc + 4` (mod 2^XLEN).
  - `upd_*` is issued for every resolved branch, correct or not, with `upd_pc = head_pc`.
- Resolve when the queue is empty, or when `res_pc != head_pc`:
  - set `order_err`;
  - no update and no redirect;
  - a mismatched head is still popped.
  - `order_err` clears only on reset.
- Full queue with simultaneous push and resolve: both are accepted and occupancy is unchanged.
- FSM states:
  - RUN: normal operation.
  - REDIRECT: entered on a mispredict. All entries are cleared, because they are younger and therefore wrong-path. A push arriving in the same cycle as the mispredict is dropped.
- REDIRECT lasts exactly 1 cycle:
  - `push_ready` = 0;
  - `res_valid` is ignored;
  - returns to RUN.

## Timing
- Resolve sampled at edge N drives `upd_valid`, `misprediction`, `redirect_valid` and `flush` high during cycle N+1. All of these are registered, single-cycle pulses.
- `push_ready` is combinational from occupancy and state.
- A push at edge N is visible in `occupancy` in cycle N+1.
- Reset values:
  - all pulses, `upd_*`, `redirect_pc` and `order_err` = 0;
  - `occupancy` = 0 and state = RUN;
  - counters = 0;
  - `push_ready` = 1 once reset is deasserted.
- Reset asserted mid-redirect: the queue and FSM clear immediately (asynchronously) and no pulse survives.

## Configuration
- `BRU_PERF_CNT_EN` defined:
  - `br_count` increments on each valid resolve;
  - `mp_count` increments on each mispredict;
  - both saturate at 0xFFFF_FFFF.
- Not defined: both ports tie to 0 and no counter flops are built.

## Structure
- `bru_pkg` holds:
  - the `bru_entry_t` struct (pc, pred_taken, pred_target);
  - the `bru_state_e` enum (RUN, REDIRECT);
  - the default DEPTH and XLEN constants.
- Sub-module `bru_pred_queue`: parameterised FIFO with push, pop, clear, full, empty and count. The top level holds the comparison logic, FSM and counters.

## Test plan
- Push pc 0x100 (pred NT); resolve NT at 0x100 → `upd_valid` with upd_taken=0; no `misprediction`; occupancy 1→0.
- Push 0x200 (pred T, 0x300); resolve T with target 0x340 → `misprediction`, `redirect_pc`=0x340 and `flush` for 1 cycle; `push_ready`=0 that cycle.
- Push 0x400, 0x404, 0x408 (pred T); resolve 0x400 NT → `redirect_pc`=0x404; occupancy goes to 0 (younger entries killed).
- Fill 4 entries: `push_ready`=0; a 5th push is dropped. Then push and resolve in the same cycle while full → occupancy stays 4. Run 10 push/pop pairs to cover pointer wrap.
- Resolve with the queue empty → `order_err`=1 and stays set, no `upd_valid`. Resolve res_pc 0x500 against head 0x504 → `order_err`, head popped.
- With `BRU_PERF_CNT_EN` defined: 3 resolves including 1 mispredict → br_count=3, mp_count=1. Without it, both read 0.
